if_prefetch_queue: RTL
======================

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning instruction address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-007 SHALL have port freeze  input  1  ID hazard stall; head entry not consumed.
REQ-008 SHALL have port branch_taken  input  1  flush and redirect request.
REQ-009 SHALL have port branch_address  input  ADDR_W  redirect target.
REQ-010 SHALL have port imem_req  output  1  instruction memory request.
REQ-011 SHALL have port imem_addr  output  ADDR_W  request address, word aligned.
REQ-012 SHALL have port imem_ack  input  1  memory completion, valid only while imem_req=1.
REQ-013 SHALL have port imem_rdata  input  DATA_W  instruction, valid with imem_ack.
REQ-014 SHALL have port out_valid  output  1  head entry present.
REQ-015 SHALL have port out_pc  output  ADDR_W  head fetch address + 4.
REQ-016 SHALL have port out_instruction  output  DATA_W  head instruction.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 SHALL implement FSM states S_IDLE (no request), S_REQ (request for fetch_pc outstanding), S_DISCARD (stale request outstanding, result dropped).
REQ-019 SHALL assert imem_req iff state is S_REQ or S_DISCARD, holding imem_addr stable (req_addr register) until the cycle imem_ack=1.
REQ-020 SHALL accept imem_ack in the first cycle of a request (zero-wait memory allowed); at most one request outstanding.
REQ-021 SHALL pop head at an edge where out_valid=1, freeze=0, branch_taken=0.
REQ-022 SHALL on ack in S_REQ without branch_taken push {req_addr+4, imem_rdata} at tail and set fetch_pc = req_addr+4.
REQ-023 SHALL issue a new request only when count after this edge's push/pop is < DEPTH; S_REQ->S_REQ on ack if room remains, else S_REQ->S_IDLE.
REQ-024 SHALL move S_IDLE->S_REQ (req_addr=fetch_pc) when count < DEPTH.
REQ-025 SHALL on branch_taken clear all entries (count=0, out_valid=0 next cycle) and set fetch_pc=branch_address.
REQ-026 SHALL on branch_taken in S_IDLE, or in S_REQ with same-cycle ack, drop any ack data and go to S_REQ with req_addr=branch_address.
REQ-027 SHALL on branch_taken in S_REQ without ack go to S_DISCARD, keeping req_addr unchanged.
REQ-028 SHALL in S_DISCARD drop ack data and on ack go to S_REQ with req_addr=fetch_pc; further branch_taken in S_DISCARD only updates fetch_pc.
REQ-029 SHALL give priority branch_taken > push/pop; freeze never blocks a flush.
REQ-030 SHALL allow simultaneous push and pop when full (count stays DEPTH), never overflow, never pop when empty.
REQ-031 SHALL use pointer wrap-around modulo DEPTH; fetch_pc arithmetic wraps modulo 2^ADDR_W.
REQ-032 SHALL present head entry combinationally from storage, latency ack->out_valid = 1 cycle.

Reset
REQ-033 SHALL while rst=0 hold state=S_IDLE, fetch_pc=req_addr=RESET_PC, count=0, out_valid=0, imem_req=0, imem_addr=RESET_PC, out_pc=0, out_instruction=0.
REQ-034 SHALL on reset mid-request abandon the outstanding request; an ack arriving while imem_req=0 is ignored.
REQ-035 SHALL assert imem_req with imem_addr=RESET_PC on the second rising edge after rst deasserts.

Verification
REQ-036 SHALL test: zero-wait memory, freeze=0, RESET_PC=0 -> out_pc 4,8,12,... one per cycle, instructions in order.
REQ-037 SHALL test: freeze=1 held, ack every cycle, DEPTH=4 -> count reaches 4, imem_req drops, head stays out_pc=4; freeze=0 -> resumes, no loss or duplicate.
REQ-038 SHALL test: 3-cycle memory, branch_taken with branch_address=0x100 one cycle after request to 0x8 -> 0x8 data dropped, next request 0x100, next out_pc=0x104.
REQ-039 SHALL test: branch_taken coincident with ack and freeze=1, queue full -> queue empty next cycle, imem_addr=branch_address immediately.
REQ-040 SHALL test: rst pulled low during outstanding request with count=2 -> all outputs at reset values, late ack ignored, fetch restarts at RESET_PC.
REQ-041 SHALL test: DEPTH=2, ADDR_W=16, fetch across 0xFFFC -> next address 0x0000, pointers wrap correctly.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: keeps up to DEPTH sequential fetches ahead of decode,
// with one outstanding memory request and flush/redirect on taken branches.
module if_prefetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     branch_taken,
  input  logic [ADDR_W-1:0]        branch_address,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0]   Full = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] Step = ADDR_W'(4);

  typedef enum logic [1:0] {SIdle, SReq, SDiscard} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              armed_q;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              push, pop;
  logic [CntW-1:0]   count_after;
  logic [ADDR_W-1:0] next_pc;

  always_comb begin
    pop         = (count_q != '0) && !freeze && !branch_taken;
    push        = (state_q == SReq) && imem_ack && !branch_taken;
    count_after = count_q + CntW'(push) - CntW'(pop);
    next_pc     = req_addr_q + Step;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (branch_taken) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_after;
    end

    unique case (state_q)
      SIdle: begin
        if (branch_taken) begin
          fetch_pc_d = branch_address;
          req_addr_d = branch_address;
          state_d    = SReq;
        end else if (armed_q && (count_q < Full)) begin
          req_addr_d = fetch_pc_q;
          state_d    = SReq;
        end
      end
      SReq: begin
        if (branch_taken) begin
          fetch_pc_d = branch_address;
          // Without an ack the old request is still in flight and must be drained first.
          if (imem_ack) req_addr_d = branch_address;
          else          state_d    = SDiscard;
        end else if (imem_ack) begin
          fetch_pc_d = next_pc;
          if (count_after < Full) req_addr_d = next_pc;
          else                    state_d    = SIdle;
        end
      end
      SDiscard: begin
        if (branch_taken) fetch_pc_d = branch_address;
        if (imem_ack) begin
          req_addr_d = branch_taken ? branch_address : fetch_pc_q;
          state_d    = SReq;
        end
      end
      default: state_d = SIdle;
    endcase
  end

  // armed_q holds off the first request by one cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      armed_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= next_pc;
      data_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    imem_req        = (state_q != SIdle);
    imem_addr       = req_addr_q;
    out_valid       = (count_q != '0);
    out_pc          = out_valid ? pc_mem[rd_ptr_q] : '0;
    out_instruction = out_valid ? data_mem[rd_ptr_q] : '0;
    count           = count_q;
  end

endmodule
